// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between fetch (read-only) and exec (load/store).
// Latency: request sampled in IDLE -> mem_req next cycle; mem_ready -> owner ready pulse next cycle, then one RELEASE cycle.
// Backpressure: requesters hold req until their ready pulse; optional MEM_ARBITER_ROUND_ROBIN_EN alternates on contention.
module mem_arbiter #(
  parameter int         M_WIDTH    = 8,
  parameter int         TIMEOUT    = 16,
  parameter logic [1:0] MEM_ACC_32 = 2'b10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               f_req,
  input  logic [M_WIDTH-1:0] f_addr,
  output logic [M_WIDTH-1:0] f_rdata,
  output logic               f_ready,
  input  logic               e_req,
  input  logic               e_we,
  input  logic [M_WIDTH-1:0] e_addr,
  input  logic [M_WIDTH-1:0] e_wdata,
  input  logic [1:0]         e_acc_width,
  output logic [M_WIDTH-1:0] e_rdata,
  output logic               e_ready,
  output logic               mem_req,
  output logic               mem_we,
  output logic [M_WIDTH-1:0] mem_addr,
  output logic [M_WIDTH-1:0] mem_data_out,
  output logic [1:0]         mem_acc_width,
  input  logic [M_WIDTH-1:0] mem_data_in,
  input  logic               mem_ready,
  output logic [1:0]         grant,
  output logic               timeout_err
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RELEASE} state_t;

  localparam logic [1:0] G_NONE  = 2'b00;
  localparam logic [1:0] G_FETCH = 2'b01;
  localparam logic [1:0] G_EXEC  = 2'b10;

  // Counter only has to reach TIMEOUT-1; expiry is detected on that value.
  localparam int             WD_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT > 0) ? WD_W'(TIMEOUT - 1) : '0;

  state_t              r_state;
  logic [WD_W-1:0]     r_wdog;
  logic                r_mem_req;
  logic                r_mem_we;
  logic [M_WIDTH-1:0]  r_mem_addr;
  logic [M_WIDTH-1:0]  r_mem_data_out;
  logic [1:0]          r_mem_acc_width;
  logic [1:0]          r_grant;
  logic [M_WIDTH-1:0]  r_f_rdata;
  logic [M_WIDTH-1:0]  r_e_rdata;
  logic                r_f_ready;
  logic                r_e_ready;
  logic                r_timeout_err;

  logic                w_pick_exec;
  logic                w_expire;
  logic                w_done;
  logic [M_WIDTH-1:0]  w_result;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  // 1 = exec owned the previous grant, 0 = fetch.
  logic r_last_exec;

  // On contention the requester that did not own the previous grant wins.
  always_comb begin
    w_pick_exec = e_req && (!f_req || !r_last_exec);
  end

  // Remember the owner of each new grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_exec <= 1'b0;
    end else if (r_state == S_IDLE && (f_req || e_req)) begin
      r_last_exec <= w_pick_exec;
    end
  end
`else
  // Fixed priority: exec always beats fetch.
  always_comb begin
    w_pick_exec = e_req;
  end
`endif

  // A mem_ready in the expiry cycle is a normal completion, not an abort.
  assign w_expire = (TIMEOUT > 0) && (r_wdog == WD_LAST);
  assign w_done   = mem_ready || w_expire;
  assign w_result = mem_ready ? mem_data_in : '0;

  // Arbitration FSM: latch command, hold it until completion/abort, then one release cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_wdog          <= '0;
      r_mem_req       <= 1'b0;
      r_mem_we        <= 1'b0;
      r_mem_addr      <= '0;
      r_mem_data_out  <= '0;
      r_mem_acc_width <= 2'b00;
      r_grant         <= G_NONE;
      r_f_rdata       <= '0;
      r_e_rdata       <= '0;
      r_f_ready       <= 1'b0;
      r_e_ready       <= 1'b0;
      r_timeout_err   <= 1'b0;
    end else begin
      r_f_ready     <= 1'b0;
      r_e_ready     <= 1'b0;
      r_timeout_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (f_req || e_req) begin
            r_state   <= S_BUSY;
            r_mem_req <= 1'b1;
            r_wdog    <= '0;
            if (w_pick_exec) begin
              r_grant         <= G_EXEC;
              r_mem_we        <= e_we;
              r_mem_addr      <= e_addr;
              r_mem_data_out  <= e_wdata;
              r_mem_acc_width <= e_acc_width;
            end else begin
              r_grant         <= G_FETCH;
              r_mem_we        <= 1'b0;
              r_mem_addr      <= f_addr;
              r_mem_data_out  <= '0;
              r_mem_acc_width <= MEM_ACC_32;
            end
          end
        end
        S_BUSY: begin
          if (w_done) begin
            r_state       <= S_RELEASE;
            r_mem_req     <= 1'b0;
            r_grant       <= G_NONE;
            r_timeout_err <= !mem_ready;
            if (r_grant == G_EXEC) begin
              r_e_rdata <= w_result;
              r_e_ready <= 1'b1;
            end else begin
              r_f_rdata <= w_result;
              r_f_ready <= 1'b1;
            end
          end else begin
            r_wdog <= r_wdog + 1'b1;
          end
        end
        S_RELEASE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign mem_req       = r_mem_req;
  assign mem_we        = r_mem_we;
  assign mem_addr      = r_mem_addr;
  assign mem_data_out  = r_mem_data_out;
  assign mem_acc_width = r_mem_acc_width;
  assign grant         = r_grant;
  assign f_rdata       = r_f_rdata;
  assign e_rdata       = r_e_rdata;
  assign f_ready       = r_f_ready;
  assign e_ready       = r_e_ready;
  assign timeout_err   = r_timeout_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios plus randomized rounds against a transaction-level model.
// Outputs are sampled 1ns after the rising edge; inputs are driven at the same point.
// The memory responder lives in step(): it replies on the Nth mem_req cycle (N=0 means never).
module tb_mem_arbiter;
  localparam int W = 8;
  localparam int T = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         f_req, e_req, e_we, mem_ready;
  logic [W-1:0] f_addr, e_addr, e_wdata, mem_data_in;
  logic [1:0]   e_acc_width;
  logic [W-1:0] f_rdata, e_rdata, mem_addr, mem_data_out;
  logic         f_ready, e_ready, mem_req, mem_we, timeout_err;
  logic [1:0]   mem_acc_width, grant;

  int           vectors = 0;
  int           miscompares = 0;
  int           req_cnt = 0;
  int           resp_lat = 0;
  logic [W-1:0] resp_data = '0;
  logic         last_exec = 1'b0;
  logic [W-1:0] exp_f = '0;
  logic [W-1:0] exp_e = '0;

  mem_arbiter #(.M_WIDTH(W), .TIMEOUT(T), .MEM_ACC_32(2'b10)) dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_rdata(f_rdata), .f_ready(f_ready),
    .e_req(e_req), .e_we(e_we), .e_addr(e_addr), .e_wdata(e_wdata),
    .e_acc_width(e_acc_width), .e_rdata(e_rdata), .e_ready(e_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_data_out(mem_data_out), .mem_acc_width(mem_acc_width),
    .mem_data_in(mem_data_in), .mem_ready(mem_ready),
    .grant(grant), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Advance one cycle, then play the memory side for the new cycle.
  task automatic step();
    @(posedge clk);
    #1;
    if (mem_req) begin
      req_cnt++;
      mem_ready   = (resp_lat != 0) && (req_cnt == resp_lat);
      mem_data_in = mem_ready ? resp_data : W'($urandom);
    end else begin
      req_cnt     = 0;
      mem_ready   = 1'b0;
      mem_data_in = W'($urandom);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    vectors++;
    if ({mem_req, mem_we, mem_acc_width, grant, f_ready, e_ready, timeout_err} !== 9'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b, want 0", {mem_req, mem_we, mem_acc_width, grant, f_ready, e_ready, timeout_err});
    end
    vectors++;
    if ({mem_addr, mem_data_out, f_rdata, e_rdata} !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_data: got %h, want 0", {mem_addr, mem_data_out, f_rdata, e_rdata});
    end
    rst = 1'b0;
    step();
    vectors++;
    if ({mem_req, grant} !== 3'b0) begin
      miscompares++;
      $display("FAIL reset_idle: got %b, want 0", {mem_req, grant});
    end
  endtask

  task automatic test_single_fetch();
    f_addr = 8'h10; f_req = 1'b1; resp_lat = 3; resp_data = 8'hA5;
    step();
    last_exec = 1'b0;
    vectors++;
    if ({mem_req, mem_we, mem_acc_width, grant} !== 6'b101001) begin
      miscompares++;
      $display("FAIL fetch_cmd: got %b, want 101001", {mem_req, mem_we, mem_acc_width, grant});
    end
    vectors++;
    if ({mem_addr, mem_data_out} !== 16'h1000) begin
      miscompares++;
      $display("FAIL fetch_addr: got %h, want 1000", {mem_addr, mem_data_out});
    end
    for (int k = 0; k < 2; k++) begin
      step();
      vectors++;
      if ({mem_req, grant, f_ready, e_ready} !== 5'b10100) begin
        miscompares++;
        $display("FAIL fetch_hold: got %b, want 10100", {mem_req, grant, f_ready, e_ready});
      end
    end
    step();
    vectors++;
    if ({f_ready, e_ready, timeout_err, mem_req, grant} !== 6'b100000 || f_rdata !== 8'hA5) begin
      miscompares++;
      $display("FAIL fetch_done: got %b/%h, want 100000/a5", {f_ready, e_ready, timeout_err, mem_req, grant}, f_rdata);
    end
    f_req = 1'b0;
    step();
    vectors++;
    if ({f_ready, mem_req, grant} !== 4'b0 || f_rdata !== 8'hA5) begin
      miscompares++;
      $display("FAIL fetch_pulse: got %b/%h, want 0000/a5", {f_ready, mem_req, grant}, f_rdata);
    end
  endtask

  task automatic test_exec_store();
    e_req = 1'b1; e_we = 1'b1; e_addr = 8'h20; e_wdata = 8'h3C; e_acc_width = 2'b00;
    resp_lat = 1; resp_data = 8'h5A;
    step();
    vectors++;
    if ({mem_req, mem_we, mem_acc_width, grant} !== 6'b110010 || {mem_addr, mem_data_out} !== 16'h203C) begin
      miscompares++;
      $display("FAIL store_cmd: got %b/%h, want 110010/203c", {mem_req, mem_we, mem_acc_width, grant}, {mem_addr, mem_data_out});
    end
    step();
    vectors++;
    if ({e_ready, f_ready, mem_req} !== 3'b100 || e_rdata !== 8'h5A) begin
      miscompares++;
      $display("FAIL store_done: got %b/%h, want 100/5a", {e_ready, f_ready, mem_req}, e_rdata);
    end
    e_req = 1'b0; e_we = 1'b0; f_addr = 8'h33; f_req = 1'b1; resp_lat = 2; resp_data = 8'hC3;
    step();
    vectors++;
    if ({mem_req, grant, e_ready} !== 4'b0) begin
      miscompares++;
      $display("FAIL store_gap: got %b, want 0000", {mem_req, grant, e_ready});
    end
    step();
    vectors++;
    if ({mem_req, grant} !== 3'b101 || mem_addr !== 8'h33) begin
      miscompares++;
      $display("FAIL store_next: got %b/%h, want 101/33", {mem_req, grant}, mem_addr);
    end
    step(); step();
    vectors++;
    if (f_ready !== 1'b1 || f_rdata !== 8'hC3) begin
      miscompares++;
      $display("FAIL store_next_done: got %b/%h, want 1/c3", f_ready, f_rdata);
    end
    f_req = 1'b0;
    step();
    last_exec = 1'b0;
  endtask

  task automatic test_contention();
    for (int r = 0; r < 2; r++) begin
      logic first_exec;
      f_addr = W'($urandom); e_addr = W'($urandom); e_we = 1'b0; e_acc_width = 2'b01;
      f_req = 1'b1; e_req = 1'b1;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      first_exec = !last_exec;
`else
      first_exec = 1'b1;
`endif
      for (int s = 0; s < 2; s++) begin
        logic cur;
        logic [W-1:0] d;
        cur = (s == 0) ? first_exec : !first_exec;
        d = W'($urandom);
        resp_lat = 2; resp_data = d;
        if (s == 1) begin
          step();
          vectors++;
          if ({mem_req, grant} !== 3'b0) begin
            miscompares++;
            $display("FAIL contend_release: got %b, want 000", {mem_req, grant});
          end
        end
        step();
        last_exec = cur;
        vectors++;
        if (grant !== (cur ? 2'b10 : 2'b01) || mem_addr !== (cur ? e_addr : f_addr)) begin
          miscompares++;
          $display("FAIL contend_grant: got %b/%h, want %b/%h", grant, mem_addr, cur ? 2'b10 : 2'b01, cur ? e_addr : f_addr);
        end
        step(); step();
        vectors++;
        if ({f_ready, e_ready} !== (cur ? 2'b01 : 2'b10) || (cur ? e_rdata : f_rdata) !== d) begin
          miscompares++;
          $display("FAIL contend_done: got %b/%h, want %b/%h", {f_ready, e_ready}, cur ? e_rdata : f_rdata, cur ? 2'b01 : 2'b10, d);
        end
        if (cur) e_req = 1'b0; else f_req = 1'b0;
      end
      step();
    end
  endtask

  task automatic test_timeout();
    f_addr = 8'h77; f_req = 1'b1; resp_lat = 0;
    step();
    last_exec = 1'b0;
    for (int k = 0; k < T; k++) begin
      vectors++;
      if ({mem_req, timeout_err, f_ready} !== 3'b100) begin
        miscompares++;
        $display("FAIL wdog_wait: got %b, want 100 at busy cycle %0d", {mem_req, timeout_err, f_ready}, k + 1);
      end
      step();
    end
    vectors++;
    if ({timeout_err, f_ready, e_ready, mem_req, grant} !== 6'b110000 || f_rdata !== 8'h00) begin
      miscompares++;
      $display("FAIL wdog_abort: got %b/%h, want 110000/00", {timeout_err, f_ready, e_ready, mem_req, grant}, f_rdata);
    end
    f_req = 1'b0;
    step();
    vectors++;
    if ({timeout_err, f_ready, mem_req} !== 3'b0) begin
      miscompares++;
      $display("FAIL wdog_pulse: got %b, want 000", {timeout_err, f_ready, mem_req});
    end
    // Reply lands in the expiry cycle itself: normal completion wins.
    e_req = 1'b1; e_we = 1'b0; e_addr = 8'h55; resp_lat = T; resp_data = 8'h9E;
    for (int k = 0; k <= T; k++) step();
    last_exec = 1'b1;
    vectors++;
    if ({e_ready, timeout_err} !== 2'b10 || e_rdata !== 8'h9E) begin
      miscompares++;
      $display("FAIL wdog_tie: got %b/%h, want 10/9e", {e_ready, timeout_err}, e_rdata);
    end
    e_req = 1'b0;
    step();
  endtask

  task automatic test_drop_req();
    e_req = 1'b1; e_we = 1'b0; e_addr = 8'h44; resp_lat = 3; resp_data = 8'h6D;
    step();
    last_exec = 1'b1;
    e_req = 1'b0; e_addr = 8'h99; e_we = 1'b1;
    step();
    vectors++;
    if ({mem_req, mem_we, grant} !== 4'b1010 || mem_addr !== 8'h44) begin
      miscompares++;
      $display("FAIL drop_hold: got %b/%h, want 1010/44", {mem_req, mem_we, grant}, mem_addr);
    end
    step(); step();
    vectors++;
    if (e_ready !== 1'b1 || e_rdata !== 8'h6D) begin
      miscompares++;
      $display("FAIL drop_done: got %b/%h, want 1/6d", e_ready, e_rdata);
    end
    // Stray mem_ready during RELEASE and IDLE must be ignored.
    for (int k = 0; k < 3; k++) begin
      mem_ready = 1'b1; mem_data_in = W'($urandom);
      step();
      vectors++;
      if ({mem_req, f_ready, e_ready, timeout_err} !== 4'b0 || e_rdata !== 8'h6D) begin
        miscompares++;
        $display("FAIL drop_stray: got %b/%h, want 0000/6d", {mem_req, f_ready, e_ready, timeout_err}, e_rdata);
      end
    end
    e_we = 1'b0;
  endtask

  task automatic test_reset_mid_busy();
    e_req = 1'b1; e_we = 1'b0; e_addr = 8'h21; resp_lat = 0;
    step(); step();
    rst = 1'b1;
    #1;
    vectors++;
    if ({mem_req, grant, e_ready} !== 4'b0 || e_rdata !== 8'h00) begin
      miscompares++;
      $display("FAIL rst_async: got %b/%h, want 0000/00", {mem_req, grant, e_ready}, e_rdata);
    end
    e_req = 1'b0;
    step();
    rst = 1'b0;
    last_exec = 1'b0;
    exp_f = '0; exp_e = '0;
    mem_ready = 1'b1; mem_data_in = 8'hEE;
    for (int k = 0; k < 2; k++) begin
      step();
      vectors++;
      if ({f_ready, e_ready, mem_req, grant} !== 5'b0 || {f_rdata, e_rdata} !== 16'h0) begin
        miscompares++;
        $display("FAIL rst_stale: got %b/%h, want 00000/0000", {f_ready, e_ready, mem_req, grant}, {f_rdata, e_rdata});
      end
    end
  endtask

  // Transaction-level model: winner chosen by priority rule, latency = min(reply, T), spacing 2 cycles.
  task automatic test_random();
    for (int r = 0; r < 40; r++) begin
      logic want_f, want_e, first_exec;
      int   n_srv;
      want_f = 1'($urandom); want_e = 1'($urandom);
      if (!want_f && !want_e) want_f = 1'b1;
      f_addr = W'($urandom); e_addr = W'($urandom); e_wdata = W'($urandom);
      e_we = 1'($urandom); e_acc_width = 2'($urandom_range(0, 2));
      f_req = want_f; e_req = want_e;
      n_srv = int'(want_f) + int'(want_e);
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      first_exec = want_e && (!want_f || !last_exec);
`else
      first_exec = want_e;
`endif
      for (int s = 0; s < n_srv; s++) begin
        logic cur, timed;
        logic [W-1:0] d, exp_d;
        int lat, n, k, exp_k;
        cur = (s == 0) ? first_exec : !first_exec;
        lat = $urandom_range(0, T + 2);
        d = W'($urandom);
        resp_lat = lat; resp_data = d;
        n = 0;
        do begin step(); n++; end while (!mem_req && n < 8);
        last_exec = cur;
        vectors++;
        if (n !== ((s == 0) ? 1 : 2)) begin
          miscompares++;
          $display("FAIL rnd_start: got %0d cycles, want %0d", n, (s == 0) ? 1 : 2);
        end
        vectors++;
        if ({grant, mem_we, mem_acc_width, mem_addr, mem_data_out} !==
            (cur ? {2'b10, e_we, e_acc_width, e_addr, e_wdata} : {2'b01, 1'b0, 2'b10, f_addr, 8'h00})) begin
          miscompares++;
          $display("FAIL rnd_cmd: got %h, want %h", {grant, mem_we, mem_acc_width, mem_addr, mem_data_out},
                   cur ? {2'b10, e_we, e_acc_width, e_addr, e_wdata} : {2'b01, 1'b0, 2'b10, f_addr, 8'h00});
        end
        k = 0;
        while (!f_ready && !e_ready && k < 12) begin step(); k++; end
        timed = !(lat >= 1 && lat <= T);
        exp_k = timed ? T : lat;
        exp_d = timed ? '0 : d;
        if (cur) exp_e = exp_d; else exp_f = exp_d;
        vectors++;
        if (k !== exp_k || {f_ready, e_ready, timeout_err, mem_req} !== {!cur, cur, timed, 1'b0}) begin
          miscompares++;
          $display("FAIL rnd_done: got %0d cycles/%b, want %0d/%b", k, {f_ready, e_ready, timeout_err, mem_req}, exp_k, {!cur, cur, timed, 1'b0});
        end
        vectors++;
        if ({f_rdata, e_rdata} !== {exp_f, exp_e}) begin
          miscompares++;
          $display("FAIL rnd_rdata: got %h, want %h", {f_rdata, e_rdata}, {exp_f, exp_e});
        end
        if (cur) e_req = 1'b0; else f_req = 1'b0;
      end
      step();
      vectors++;
      if ({f_ready, e_ready, timeout_err, mem_req, grant} !== 6'b0) begin
        miscompares++;
        $display("FAIL rnd_idle: got %b, want 000000", {f_ready, e_ready, timeout_err, mem_req, grant});
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    f_req = 1'b0; e_req = 1'b0; e_we = 1'b0; mem_ready = 1'b0;
    f_addr = '0; e_addr = '0; e_wdata = '0; e_acc_width = 2'b00; mem_data_in = '0;
    test_reset();
    test_single_fetch();
    test_exec_store();
    test_contention();
    test_timeout();
    test_drop_req();
    test_reset_mid_busy();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, want finish before 500000");
    $fatal(1);
  end

endmodule
